// File: rtl/ysyx_22040759_exe_mdu.sv
// Execute stage with an iterative multiply/divide unit.
// Single-cycle ALU ops; MUL/MULHU shift-add and DIV/DIVU/REM/REMU restoring
// division run over XLEN cycles and hold off decode until the result is done.
// Optional feature macro: YSYX_22040759_DIV_EN enables the divider. Without it,
// ops 12-15 finish in one cycle and return 0.
module ysyx_22040759_exe_mdu #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            ds_to_es_valid,
    output logic            es_allowin,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic [XLEN-1:0] in_pc,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] ms_fwd_data,
    input  logic [XLEN-1:0] ws_fwd_data,
    output logic [4:0]      es_rs1,
    output logic [4:0]      es_rs2,
    input  logic            ms_allowin,
    output logic            es_to_ms_valid,
    output logic [XLEN-1:0] es_result,
    output logic [4:0]      es_rd,
    output logic            es_wen,
    output logic [XLEN-1:0] es_pc,
    output logic            es_busy
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;

    mdu_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic            es_valid, es_ready_go, load, is_mdu;
    logic [3:0]      op_r;
    logic [XLEN-1:0] src1_r, src2_r, op_a, op_b;
    logic [XLEN-1:0] acc, lo, dvs;
    logic [XLEN-1:0] alu_res, mdu_res;
    logic [XLEN:0]   mul_sum;

    assign es_ready_go    = is_mdu ? (state == DONE) : 1'b1;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign load           = ds_to_es_valid && es_allowin && !flush;
    assign es_busy        = (state == RUN);

    // Pipeline payload register; flush wins over a simultaneous load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            es_valid <= 1'b0;
            op_r     <= '0;
            src1_r   <= '0;
            src2_r   <= '0;
            es_rs1   <= '0;
            es_rs2   <= '0;
            es_rd    <= '0;
            es_wen   <= 1'b0;
            es_pc    <= '0;
        end else if (flush) begin
            es_valid <= 1'b0;
        end else if (load) begin
            es_valid <= 1'b1;
            op_r     <= in_op;
            src1_r   <= in_src1;
            src2_r   <= in_src2;
            es_rs1   <= in_rs1;
            es_rs2   <= in_rs2;
            es_rd    <= in_rd;
            es_wen   <= in_wen;
            es_pc    <= in_pc;
        end else if (es_allowin) begin
            es_valid <= 1'b0;
        end
    end

    // Operand forwarding, re-evaluated every cycle; 11 falls back to the latched operand
    always_comb begin
        case (ForwardA)
            2'b10:   op_a = ms_fwd_data;
            2'b01:   op_a = ws_fwd_data;
            default: op_a = src1_r;
        endcase
        case (ForwardB)
            2'b10:   op_b = ms_fwd_data;
            2'b01:   op_b = ws_fwd_data;
            default: op_b = src2_r;
        endcase
    end

    // Single-cycle ALU; ops without hardware fall through to 0
    always_comb begin
        case (op_r)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd7:    alu_res = op_a << op_b[SH_W-1:0];
            4'd8:    alu_res = op_a >> op_b[SH_W-1:0];
            4'd9:    alu_res = $unsigned($signed(op_a) >>> op_b[SH_W-1:0]);
            default: alu_res = '0;
        endcase
    end

    // One shift-add multiply step: acc holds the product high half, lo the multiplier/low half
    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : {(XLEN+1){1'b0}});

`ifdef YSYX_22040759_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic            is_div, is_sdiv, a_neg, b_neg, div0, ovf, ge, neg_q, neg_r;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   shifted, diff;

    assign is_mdu  = op_r[3] && (op_r[2] || op_r[1]);
    assign is_div  = op_r[3] && op_r[2];
    assign is_sdiv = is_div && !op_r[0];
    assign a_neg   = is_sdiv && op_a[XLEN-1];
    assign b_neg   = is_sdiv && op_b[XLEN-1];
    assign a_mag   = a_neg ? -op_a : op_a;
    assign b_mag   = b_neg ? -op_b : op_b;
    assign div0    = (op_b == '0);
    assign ovf     = is_sdiv && (op_a == MIN_NEG) && (op_b == '1);
    // Restoring step: acc is the partial remainder, lo shifts dividend out and quotient in
    assign shifted = {acc, lo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = (shifted >= {1'b0, dvs});

    // MDU result selection with sign fix-up applied on the way out
    always_comb begin
        case (op_r)
            4'd10:       mdu_res = lo;
            4'd11:       mdu_res = acc;
            4'd12, 4'd13: mdu_res = neg_q ? -lo : lo;
            default:     mdu_res = neg_r ? -acc : acc;
        endcase
    end

    // MDU control and datapath; special divide cases jump straight to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            lo    <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (es_valid && is_mdu) begin
                    cnt <= '0;
                    if (!is_div) begin
                        acc   <= '0;
                        lo    <= op_a;
                        dvs   <= op_b;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= RUN;
                    end else if (div0) begin
                        acc   <= op_a;
                        lo    <= '1;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DONE;
                    end else if (ovf) begin
                        acc   <= '0;
                        lo    <= MIN_NEG;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= DONE;
                    end else begin
                        acc   <= '0;
                        lo    <= a_mag;
                        dvs   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                        lo  <= {lo[XLEN-2:0], ge};
                    end else begin
                        acc <= mul_sum[XLEN:1];
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                    if (cnt == CNT_W'(XLEN-1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: if (es_to_ms_valid && ms_allowin) state <= IDLE;
            endcase
        end
    end
`else
    assign is_mdu  = (op_r[3:1] == 3'b101);
    assign mdu_res = op_r[0] ? acc : lo;

    // Multiply-only MDU control and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            lo    <= '0;
            dvs   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (es_valid && is_mdu) begin
                    cnt   <= '0;
                    acc   <= '0;
                    lo    <= op_a;
                    dvs   <= op_b;
                    state <= RUN;
                end
                RUN: begin
                    acc <= mul_sum[XLEN:1];
                    lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    if (cnt == CNT_W'(XLEN-1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: if (es_to_ms_valid && ms_allowin) state <= IDLE;
            endcase
        end
    end
`endif

    // Result is forced to 0 when the stage holds nothing
    assign es_result = es_valid ? (is_mdu ? mdu_res : alu_res) : '0;

endmodule

// File: tb/tb_ysyx_22040759_exe_mdu.sv
// Randomized and directed bench for ysyx_22040759_exe_mdu (XLEN=64).
module tb_ysyx_22040759_exe_mdu;
    localparam int XLEN = 64;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ds_to_es_valid = 1'b0;
    logic        es_allowin, es_to_ms_valid, es_wen, es_busy;
    logic [3:0]  in_op = '0;
    logic [63:0] in_src1 = '0, in_src2 = '0, in_pc = '0, ms_fwd_data = '0, ws_fwd_data = '0;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_wen = 1'b0, ms_allowin = 1'b1;
    logic [1:0]  ForwardA = '0, ForwardB = '0;
    logic [4:0]  es_rs1, es_rs2, es_rd;
    logic [63:0] es_result, es_pc;

    int checks = 0, failures = 0;

    ysyx_22040759_exe_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ds_to_es_valid(ds_to_es_valid),
        .es_allowin(es_allowin), .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_pc(in_pc),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .ms_fwd_data(ms_fwd_data),
        .ws_fwd_data(ws_fwd_data), .es_rs1(es_rs1), .es_rs2(es_rs2), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_rd(es_rd),
        .es_wen(es_wen), .es_pc(es_pc), .es_busy(es_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of each op, straight from the op definitions
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd6:  return (a < b) ? 64'd1 : 64'd0;
            4'd7:  return a << b[5:0];
            4'd8:  return a >> b[5:0];
            4'd9:  return $unsigned($signed(a) >>> b[5:0]);
            4'd10: return p[63:0];
            4'd11: return p[127:64];
`ifdef YSYX_22040759_DIV_EN
            4'd12: return (b == 0) ? ONES : (a == MINV && b == ONES) ? MINV : $unsigned($signed(a) / $signed(b));
            4'd13: return (b == 0) ? ONES : a / b;
            4'd14: return (b == 0) ? a : (a == MINV && b == ONES) ? 64'd0 : $unsigned($signed(a) % $signed(b));
            4'd15: return (b == 0) ? a : a % b;
`endif
            default: return 64'd0;
        endcase
    endfunction

    // Cycles from load edge until es_to_ms_valid (cycle 1 = right after the load edge)
    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op == 4'd10 || op == 4'd11) return XLEN + 2;
`ifdef YSYX_22040759_DIV_EN
        if (op >= 4'd12) begin
            if (b == 0) return 2;
            if (!op[0] && a == MINV && b == ONES) return 2;
            return XLEN + 2;
        end
`endif
        return 1;
    endfunction

    function automatic logic [63:0] fwd_sel(input logic [1:0] f, input logic [63:0] s, input logic [63:0] m, input logic [63:0] w);
        return (f == 2'b10) ? m : (f == 2'b01) ? w : s;
    endfunction

    // Issue one instruction, wait (bounded) for its result, optionally stall ms, then drain
    task automatic issue_op(input string tag, input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [63:0] msd, input logic [63:0] wsd,
                            input int stall, input bit kill_fwd);
        logic [63:0] a, b, exp, pc;
        logic [4:0]  rd;
        int lat, c;
        bit leak, unstable;
        a   = fwd_sel(fa, s1, msd, wsd);
        b   = fwd_sel(fb, s2, msd, wsd);
        exp = ref_res(op, a, b);
        lat = ref_lat(op, a, b);
        pc  = {$urandom, $urandom};
        rd  = 5'($urandom);
        @(negedge clk);
        chk({tag, "_allowin"}, es_allowin, 1'b1);
        in_op = op; in_src1 = s1; in_src2 = s2; ForwardA = fa; ForwardB = fb;
        ms_fwd_data = msd; ws_fwd_data = wsd; in_pc = pc; in_rd = rd; in_wen = 1'b1;
        in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
        ds_to_es_valid = 1'b1;
        ms_allowin = (stall == 0);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        c = 1;
        leak = 1'b0;
        chk({tag, "_pc"}, es_pc, pc);
        chk({tag, "_rd"}, {59'd0, es_rd}, {59'd0, rd});
        while (!es_to_ms_valid && c < 300) begin
            if (es_allowin) leak = 1'b1;
            if (c == 10 && lat > 2) chk({tag, "_busy"}, es_busy, 1'b1);
            @(negedge clk);
            c++;
            if (kill_fwd && c == 2) ms_fwd_data = 64'd0;
        end
        chk({tag, "_lat"}, 64'(c), 64'(lat));
        chk({tag, "_res"}, es_result, exp);
        if (lat > 1) chk({tag, "_blocked"}, leak, 1'b0);
        if (stall > 0) begin
            unstable = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!es_to_ms_valid || es_result !== exp || es_allowin) unstable = 1'b1;
            end
            chk({tag, "_hold"}, unstable, 1'b0);
            ms_allowin = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_drain"}, es_to_ms_valid, 1'b0);
    endtask

    // Load an op and return once it has sat n cycles in the stage
    task automatic start_op(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2, input int n);
        @(negedge clk);
        in_op = op; in_src1 = s1; in_src2 = s2; ForwardA = 2'b00; ForwardB = 2'b00;
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        bit stale;
        logic [3:0]  op;
        logic [63:0] a, b, m, w;

        #1;
        chk("rst_valid", es_to_ms_valid, 1'b0);
        chk("rst_busy", es_busy, 1'b0);
        chk("rst_result", es_result, 64'd0);
        chk("rst_pc", es_pc, 64'd0);
        chk("rst_allowin", es_allowin, 1'b1);
        #20 rst_n = 1'b1;

        issue_op("add", 4'd0, 64'd5, -64'sd3, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        chk("add_const", ref_res(4'd0, 64'd5, -64'sd3), 64'd2);
        issue_op("mul", 4'd10, ONES, 64'd2, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("mulhu", 4'd11, ONES, 64'd2, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("div", 4'd12, -64'sd7, 64'd2, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("rem", 4'd14, -64'sd7, 64'd2, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("divu0", 4'd13, 64'd7, 64'd0, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("divovf", 4'd12, MINV, ONES, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("removf", 4'd14, MINV, ONES, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);
        issue_op("fwdmul", 4'd10, 64'd123, 64'd3, 2'b10, 2'b00, 64'd9, 64'd0, 0, 1'b1);
        issue_op("fwdws", 4'd1, 64'd1, 64'd1, 2'b01, 2'b11, 64'd0, 64'd50, 0, 1'b0);
        issue_op("stall", 4'd10, 64'd6, 64'd7, 2'b00, 2'b00, 64'd0, 64'd0, 5, 1'b0);
        issue_op("stalladd", 4'd4, 64'hF0F0, 64'h0FF0, 2'b00, 2'b00, 64'd0, 64'd0, 3, 1'b0);

        // Flush during RUN, then confirm nothing stale emerges
        start_op(4'd10, 64'd3, 64'd5, 22);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", es_to_ms_valid, 1'b0);
        chk("flush_busy", es_busy, 1'b0);
        chk("flush_allowin", es_allowin, 1'b1);
        stale = 1'b0;
        repeat (XLEN + 8) begin
            @(negedge clk);
            if (es_to_ms_valid || es_busy) stale = 1'b1;
        end
        chk("flush_stale", stale, 1'b0);
        issue_op("postflush", 4'd0, 64'd1, 64'd1, 2'b00, 2'b00, 64'd0, 64'd0, 0, 1'b0);

        // Asynchronous reset in the middle of RUN
        start_op(4'd10, 64'd11, 64'd13, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", es_to_ms_valid, 1'b0);
        chk("arst_busy", es_busy, 1'b0);
        chk("arst_result", es_result, 64'd0);
        chk("arst_pc", es_pc, 64'd0);
        chk("arst_rd", {59'd0, es_rd}, 64'd0);
        chk("arst_rs", {54'd0, es_rs1, es_rs2}, 64'd0);
        chk("arst_wen", es_wen, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized ops with random forwarding and operand corner values
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = 64'd0;
                1: a = MINV;
                2: a = ONES;
                3: a = 64'($urandom_range(0, 100));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: b = 64'd0;
                1: b = ONES;
                2: b = 64'($urandom_range(1, 70));
                default: b = {$urandom, $urandom};
            endcase
            m = {$urandom, $urandom};
            w = {$urandom, $urandom};
            issue_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     m, w, (i % 7 == 3) ? 2 : 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
